// File: rtl/irq_dispatch.sv
// Two-node interrupt dispatcher. Each node synchronizes its tick/mutex/mem sources,
// latches rising edges into a pending register, and hands them out one at a time by priority.
module irq_node #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 2000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] src,
  input  logic       ack,
  input  logic       clr,
  output logic       irq,
  output logic [1:0] cause,
  output logic       ovr
);
  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;

  localparam logic [15:0] TO_LAST = 16'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [SYNC_STAGES-1:0][2:0] sync;
  logic [2:0]  hist, rise, pend, take, back, pend_nx, hit;
  logic [15:0] cnt;
  logic [1:0]  cause_nx;
  logic        load, timeout;
  state_t      state, state_nx;

  assign rise    = sync[SYNC_STAGES-1] & ~hist;
  assign timeout = (ACK_TIMEOUT != 0) && (cnt == TO_LAST);
  // An event landing on a bit being dispatched this cycle simply re-arms it.
  assign hit     = rise & pend & ~take;
  assign pend_nx = (pend & ~take) | back | rise;
  assign irq     = (state == ASSERT);

  always_comb begin
    state_nx = state;
    take     = '0;
    back     = '0;
    load     = 1'b0;
    cause_nx = cause;
    unique case (state)
      IDLE: if (|pend) begin
        load     = 1'b1;
        state_nx = ASSERT;
        if (pend[2])      begin take = 3'b100; cause_nx = 2'd3; end
        else if (pend[1]) begin take = 3'b010; cause_nx = 2'd2; end
        else              begin take = 3'b001; cause_nx = 2'd1; end
      end
      ASSERT: if (ack) state_nx = RELEASE;
        else if (timeout) begin
          state_nx = IDLE;
          unique case (cause)
            2'd3:    back = 3'b100;
            2'd2:    back = 3'b010;
            2'd1:    back = 3'b001;
            default: back = 3'b000;
          endcase
        end
      RELEASE: if (!ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync  <= '0;
      hist  <= '0;
      pend  <= '0;
      cnt   <= '0;
      cause <= '0;
      ovr   <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], src};
      hist  <= sync[SYNC_STAGES-1];
      pend  <= pend_nx;
      cause <= cause_nx;
      ovr   <= (ovr & ~clr) | (|hit);
      if (load)                                    cnt <= '0;
      else if (state == ASSERT && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end
endmodule

module irq_dispatch #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 2000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       irq0_in,
  input  logic [1:0] irq1_in,
  input  logic       irq2_node0_in,
  input  logic       irq2_node1_in,
  input  logic       node0_ack,
  input  logic       node1_ack,
  output logic       node0_irq,
  output logic       node1_irq,
  output logic [1:0] node0_cause,
  output logic [1:0] node1_cause,
  output logic [1:0] overrun,
  input  logic [1:0] clr_overrun
);
  localparam int NUM_NODES = 2;

  logic [NUM_NODES-1:0][2:0] src;
  logic [NUM_NODES-1:0][1:0] cause;
  logic [NUM_NODES-1:0]      ack, irq;

  // Source order per node: bit2 mem, bit1 mutex, bit0 tick.
  assign src[0] = {irq2_node0_in, irq1_in[0], irq0_in};
  assign src[1] = {irq2_node1_in, irq1_in[1], irq0_in};
  assign ack    = {node1_ack, node0_ack};
  assign node0_irq   = irq[0];
  assign node1_irq   = irq[1];
  assign node0_cause = cause[0];
  assign node1_cause = cause[1];

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
    irq_node #(.SYNC_STAGES(SYNC_STAGES), .ACK_TIMEOUT(ACK_TIMEOUT)) u_node (
      .CLK   (CLK),
      .RST_N (RST_N),
      .src   (src[n]),
      .ack   (ack[n]),
      .clr   (clr_overrun[n]),
      .irq   (irq[n]),
      .cause (cause[n]),
      .ovr   (overrun[n])
    );
  end
endmodule

// File: tb/tb_irq_dispatch.sv
// Scoreboard bench for irq_dispatch: stimulus queues expected irq edges, monitor pops and compares.
module tb_irq_dispatch;
  logic       CLK, RST_N;
  logic       irq0_in, irq2_node0_in, irq2_node1_in, node0_ack, node1_ack;
  logic [1:0] irq1_in, clr_overrun;
  logic       node0_irq, node1_irq;
  logic [1:0] node0_cause, node1_cause, overrun;

  irq_dispatch #(.SYNC_STAGES(2), .ACK_TIMEOUT(10)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .irq0_in       (irq0_in),
    .irq1_in       (irq1_in),
    .irq2_node0_in (irq2_node0_in),
    .irq2_node1_in (irq2_node1_in),
    .node0_ack     (node0_ack),
    .node1_ack     (node1_ack),
    .node0_irq     (node0_irq),
    .node1_irq     (node1_irq),
    .node0_cause   (node0_cause),
    .node1_cause   (node1_cause),
    .overrun       (overrun),
    .clr_overrun   (clr_overrun)
  );

  typedef struct {
    bit       rise;
    logic [1:0] cause;
    int       cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  cyc = 0;
  int  total = 0;
  int  passed = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic push(int n, bit r, logic [1:0] c, int cy);
    ev_t e;
    e.rise = r; e.cause = c; e.cyc = cy;
    if (n == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h (cyc %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  task automatic mon(int n, bit r, logic [1:0] c);
    ev_t e;
    total++;
    if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
      $display("FAIL unexpected_edge node%0d: got rise=%0d cause=%0d cyc=%0d, required none", n, r, c, cyc);
      return;
    end
    e = (n == 0) ? q0.pop_front() : q1.pop_front();
    if (e.rise != r || e.cause !== c || e.cyc != cyc)
      $display("FAIL edge node%0d: got rise=%0d cause=%0d cyc=%0d, required rise=%0d cause=%0d cyc=%0d",
               n, r, c, cyc, e.rise, e.cause, e.cyc);
    else passed++;
  endtask

  // Monitor: every irq transition is a DUT output event matched against the queue.
  initial begin
    logic [1:0] prev, cur;
    prev = 2'b00;
    forever begin
      @(posedge CLK);
      #1;
      cur = {node1_irq, node0_irq};
      if (cur[0] != prev[0]) mon(0, cur[0], node0_cause);
      if (cur[1] != prev[1]) mon(1, cur[1], node1_cause);
      prev = cur;
    end
  end

  task automatic at(int c);
    while (cyc < c) @(negedge CLK);
  endtask

  initial begin
    int b;
    RST_N = 1'b0; irq0_in = 0; irq1_in = '0; irq2_node0_in = 0; irq2_node1_in = 0;
    node0_ack = 0; node1_ack = 0; clr_overrun = '0;
    repeat (3) @(negedge CLK);
    chk("rst_node0_irq", 8'(node0_irq), 8'd0);
    chk("rst_node1_irq", 8'(node1_irq), 8'd0);
    chk("rst_node0_cause", 8'(node0_cause), 8'd0);
    chk("rst_node1_cause", 8'(node1_cause), 8'd0);
    chk("rst_overrun", 8'(overrun), 8'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Single mem event on node0, ack after 5 cycles.
    b = cyc;
    irq2_node0_in = 1;
    push(0, 1, 2'd3, b + 4); push(0, 0, 2'd3, b + 10);
    at(b + 2);  irq2_node0_in = 0;
    at(b + 9);  node0_ack = 1;
    at(b + 10); node0_ack = 0;
    at(b + 20);
    chk("t1_node1_irq", 8'(node1_irq), 8'd0);
    chk("t1_node1_cause", 8'(node1_cause), 8'd0);

    // Tick and mutex[1] together: node1 takes mutex first, then tick.
    b = cyc;
    irq0_in = 1; irq1_in = 2'b10;
    push(0, 1, 2'd1, b + 4);  push(1, 1, 2'd2, b + 4);
    push(0, 0, 2'd1, b + 7);  push(1, 0, 2'd2, b + 7);
    push(1, 1, 2'd1, b + 10); push(1, 0, 2'd1, b + 13);
    at(b + 2);  irq0_in = 0; irq1_in = '0;
    at(b + 6);  node0_ack = 1; node1_ack = 1;
    at(b + 7);  node0_ack = 0;
    at(b + 8);  node1_ack = 0;
    at(b + 12); node1_ack = 1;
    at(b + 13); node1_ack = 0;
    at(b + 20);

    // Ack timeout: 10 cycles high, 1 low, re-dispatched with same cause.
    b = cyc;
    irq2_node0_in = 1;
    push(0, 1, 2'd3, b + 4);  push(0, 0, 2'd3, b + 14);
    push(0, 1, 2'd3, b + 15); push(0, 0, 2'd3, b + 17);
    at(b + 2);  irq2_node0_in = 0;
    at(b + 16); node0_ack = 1;
    at(b + 17); node0_ack = 0;
    at(b + 25);
    chk("t3_overrun", 8'(overrun), 8'd0);

    // Two ticks while node0 sits in ASSERT on mem: overrun, then clear.
    b = cyc;
    irq2_node0_in = 1;
    push(0, 1, 2'd3, b + 4);  push(0, 0, 2'd3, b + 11);
    push(0, 1, 2'd1, b + 13); push(0, 0, 2'd1, b + 15);
    push(1, 1, 2'd1, b + 8);  push(1, 0, 2'd1, b + 11);
    push(1, 1, 2'd1, b + 13); push(1, 0, 2'd1, b + 15);
    at(b + 1);  irq2_node0_in = 0;
    at(b + 4);  irq0_in = 1;
    at(b + 5);  irq0_in = 0;
    at(b + 6);  irq0_in = 1;
    at(b + 7);  irq0_in = 0;
    at(b + 8);  chk("t4_overrun_before", 8'(overrun), 8'd0);
    at(b + 9);  chk("t4_overrun_set", 8'(overrun), 8'd1);
    at(b + 10); node0_ack = 1; node1_ack = 1;
    at(b + 11); node0_ack = 0; node1_ack = 0;
    at(b + 14); node0_ack = 1; node1_ack = 1;
    at(b + 15); node0_ack = 0; node1_ack = 0;
    at(b + 16); chk("t4_overrun_sticky", 8'(overrun), 8'd1);
    clr_overrun = 2'b01;
    at(b + 17); clr_overrun = 2'b00;
    chk("t4_overrun_clr", 8'(overrun), 8'd0);
    at(b + 25);

    // Reset mid-ASSERT drops irq and cause asynchronously; nothing afterwards.
    b = cyc;
    irq2_node0_in = 1;
    push(0, 1, 2'd3, b + 4); push(0, 0, 2'd0, b + 7);
    at(b + 1); irq2_node0_in = 0;
    at(b + 6); RST_N = 1'b0;
    #1;
    chk("t5_async_irq", 8'(node0_irq), 8'd0);
    chk("t5_async_cause", 8'(node0_cause), 8'd0);
    at(b + 8); RST_N = 1'b1;
    at(b + 24);
    chk("t5_overrun", 8'(overrun), 8'd0);

    chk("q0_drained", 8'(q0.size()), 8'd0);
    chk("q1_drained", 8'(q1.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2 (range 2..4): synchronizer depth on every interrupt input.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 2000 (range 0..65535): max cycles in ASSERT awaiting ack; 0 = no timeout.
REQ-003 SHALL have port CLK  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port irq0_in  in  1  periodic tick from interrupt generator, broadcast to both nodes.
REQ-006 SHALL have port irq1_in  in  2  mutex interrupt; bit0 -> node0, bit1 -> node1.
REQ-007 SHALL have port irq2_node0_in / irq2_node1_in  in  1 each  memory-bound interrupt per node.
REQ-008 SHALL have port node0_ack / node1_ack  in  1 each  node acknowledge, level.
REQ-009 SHALL have port node0_irq / node1_irq  out  1 each  interrupt request to node.
REQ-010 SHALL have port node0_cause / node1_cause  out  2 each  0 none, 1 tick, 2 mutex, 3 mem.
REQ-011 SHALL have port overrun  out  2  sticky per-node lost-event flag (bit n = node n).
REQ-012 SHALL have port clr_overrun  in  2  synchronous clear of overrun bit n.

Function
REQ-013 SHALL pass each input through a SYNC_STAGES-flop synchronizer, then a rising-edge detector (one event per low->high transition, regardless of pulse width).
REQ-014 SHALL keep per node a 3-bit pending register: bit0 tick, bit1 mutex, bit2 mem; an event sets its bit.
REQ-015 SHALL set overrun[n] when an event hits an already-set pending bit of node n; set wins over a same-cycle clr_overrun[n].
REQ-016 SHALL, when an event arrives in the same cycle its pending bit is consumed by dispatch, leave the bit set and not flag overrun.
REQ-017 SHALL run an independent FSM per node: IDLE, ASSERT, RELEASE.
REQ-018 SHALL in IDLE with pending != 0: select highest priority (mem > mutex > tick), clear that bit, load cause, drive irq=1 next cycle, enter ASSERT.
REQ-019 SHALL in ASSERT hold irq=1 and cause stable; on ack=1 drive irq=0 next cycle and enter RELEASE.
REQ-020 SHALL in ASSERT, ACK_TIMEOUT != 0 and timeout counter reaching ACK_TIMEOUT without ack: drive irq=0, re-set the dispatched pending bit, enter IDLE.
REQ-021 SHALL in RELEASE keep irq=0 and wait for ack=0, then enter IDLE; cause holds last value until next dispatch.
REQ-022 SHALL use a 16-bit timeout counter per node, cleared on entering ASSERT, saturating, never wrapping.
REQ-023 SHALL give latency from input high (setup met before edge 1) to irq high at edge SYNC_STAGES+2 when node is IDLE with nothing pending.
REQ-024 SHALL ignore ack while IDLE; an ack held high from a previous cycle into ASSERT counts as immediate ack.
REQ-025 SHALL not re-prioritise mid-ASSERT: a higher-priority event arriving during ASSERT waits in pending.

Reset
REQ-026 SHALL on RST_N low immediately clear synchronizers, edge-detect history, pending, timeout counters, overrun; outputs irq=0, cause=0, overrun=0; FSMs IDLE.
REQ-027 SHALL treat an input already high at reset release as a rising edge (edge history resets to 0).
REQ-028 SHALL abort any in-flight dispatch on reset assertion mid-ASSERT; no event is restored.

Verification
REQ-029 SHALL cover: irq2_node0_in 0->1, ack after 5 cycles -> node0_irq rises edge 4, cause=3, falls one cycle after ack; node1 untouched.
REQ-030 SHALL cover: tick and mutex[1] rise same cycle -> node1 dispatches cause=2 first, then cause=1 after ack high->low; node0 gets cause=1 only.
REQ-031 SHALL cover: ACK_TIMEOUT=10, no ack -> node0_irq high 10 cycles, low 1 cycle, re-asserted with same cause; overrun stays 0.
REQ-032 SHALL cover: two tick pulses while node0 in ASSERT -> overrun[0]=1 on second; clr_overrun[0] pulse -> overrun[0]=0 next cycle.
REQ-033 SHALL cover: RST_N low mid-ASSERT -> node_irq=0 and cause=0 without a clock edge; after release with inputs low, no irq.
